// File: rtl/cail_param_pkg.sv
// cail_param_pkg
// Shared definitions for the calibration-parameter store: the controller
// state encoding and the default geometry / sweep value.
package cail_param_pkg;

  // Controller states: ST_INIT runs the initialisation sweep, ST_IDLE
  // accepts user writes.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_INIT_VAL = 0;

endpackage

// File: rtl/cail_param_ram.sv
// cail_param_ram
// Inferable simple-dual-port RAM: one synchronous write port, one read
// port with a registered output. Same-address read and write on one edge
// returns the previous contents (read-first). The array is not reset.
//
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, sampled every cycle
//   rdata  out  registered read data
module cail_param_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    rdata_reg <= mem_reg[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/cail_param_store.sv
// cail_param_store
// Calibration-parameter store: simple-dual-port RAM with a self-clearing
// initialisation sweep (after reset or on clear), per-entry "written"
// flags, and optional same-address read-during-write bypass.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   clear      in   one-cycle request to re-run the init sweep
//   data       in   write data
//   wraddress  in   write address
//   wren       in   write enable
//   rdaddress  in   read address, sampled every cycle
//   q          out  read data, one cycle after rdaddress
//   q_valid    out  entry read into q was written since the last sweep
//   busy       out  init sweep in progress
//   wr_err     out  one-cycle pulse: a write was dropped
module cail_param_store
  import cail_param_pkg::*;
#(
  parameter int                DATA_W   = DEFAULT_DATA_W,
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEFAULT_INIT_VAL),
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy,
  output logic              wr_err
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              sweep_we;
  logic              user_we;
  logic              drop_wr;
  logic              byp_hit;

  logic [DEPTH-1:0]  written_reg;
  logic              wr_err_reg;
  logic              q_valid_reg;
  // When ovr_reg is set, q comes from ovr_data_reg instead of the RAM:
  // used for the reset value, reads during the sweep, and bypass hits.
  logic              ovr_reg;
  logic [DATA_W-1:0] ovr_data_reg;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Next-state and write-port arbitration.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sweep_we   = 1'b0;
    user_we    = 1'b0;
    drop_wr    = 1'b0;
    case (state_reg)
      ST_INIT: begin
        sweep_we = 1'b1;
        drop_wr  = wren;
        if (clear) begin
          ptr_next = '0;
        end else if (ptr_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          // clear takes priority over a simultaneous user write
          state_next = ST_INIT;
          ptr_next   = '0;
          drop_wr    = wren;
        end else begin
          user_we = wren;
        end
      end
    endcase
  end

  assign ram_we    = !reset && (sweep_we || user_we);
  assign ram_waddr = sweep_we ? ptr_reg : wraddress;
  assign ram_wdata = sweep_we ? INIT_VAL : data;
  assign byp_hit   = BYPASS && user_we && (wraddress == rdaddress);

  cail_param_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rdaddress),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      ptr_reg      <= '0;
      wr_err_reg   <= 1'b0;
      ovr_reg      <= 1'b1;
      ovr_data_reg <= '0;
      q_valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      wr_err_reg <= drop_wr;
      if (state_reg == ST_INIT) begin
        ovr_reg      <= 1'b1;
        ovr_data_reg <= INIT_VAL;
        q_valid_reg  <= 1'b0;
      end else if (byp_hit) begin
        ovr_reg      <= 1'b1;
        ovr_data_reg <= data;
        q_valid_reg  <= 1'b1;
      end else begin
        // Flag is sampled before this edge's update, matching the
        // read-first RAM when bypass is disabled.
        ovr_reg     <= 1'b0;
        q_valid_reg <= written_reg[rdaddress];
      end
    end
  end

  // Per-entry written flags; any clear (or reset) wipes them all.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_written
      always_ff @(posedge clock) begin
        if (reset || clear) begin
          written_reg[gi] <= 1'b0;
        end else if (user_we && (wraddress == ADDR_W'(gi))) begin
          written_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign q       = ovr_reg ? ovr_data_reg : ram_rdata;
  assign q_valid = q_valid_reg;
  assign busy    = (state_reg == ST_INIT);
  assign wr_err  = wr_err_reg;

endmodule

// File: tb/tb_cail_param_store.sv
// tb_cail_param_store
// Two instances share one stimulus stream: one with bypass enabled, one
// without. Each driven cycle pushes the hand-computed response expected
// after that clock edge; a monitor pops and compares after every edge.
module tb_cail_param_store;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [7:0] data;
  logic [4:0] wraddress;
  logic       wren;
  logic [4:0] rdaddress;

  logic [7:0] q1, q0;
  logic       qv1, qv0;
  logic       busy1, busy0;
  logic       err1, err0;

  cail_param_store #(.DATA_W(8), .ADDR_W(5), .INIT_VAL(8'h00), .BYPASS(1'b1)) u_byp (
    .clock     (clk),
    .reset     (reset),
    .clear     (clear),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .q         (q1),
    .q_valid   (qv1),
    .busy      (busy1),
    .wr_err    (err1)
  );

  cail_param_store #(.DATA_W(8), .ADDR_W(5), .INIT_VAL(8'h00), .BYPASS(1'b0)) u_old (
    .clock     (clk),
    .reset     (reset),
    .clear     (clear),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .q         (q0),
    .q_valid   (qv0),
    .busy      (busy0),
    .wr_err    (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    bit         cq;
    logic [7:0] q1;
    logic       v1;
    logic [7:0] q0;
    logic       v0;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step  = 0;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, want);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic cyc(input bit rst, input bit clr, input bit we, input logic [4:0] wa,
                     input logic [7:0] wd, input logic [4:0] ra, input bit cq,
                     input logic [7:0] eq1, input logic ev1, input logic [7:0] eq0,
                     input logic ev0, input logic ebusy, input logic eerr);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    clear     = clr;
    wren      = we;
    wraddress = wa;
    data      = wd;
    rdaddress = ra;
    e.id = step; e.cq = cq; e.q1 = eq1; e.v1 = ev1; e.q0 = eq0; e.v0 = ev0;
    e.busy = ebusy; e.err = eerr;
    exp_q.push_back(e);
    step++;
  endtask

  // 32 cycles following a reset/clear edge: busy stays up until the last one.
  // A write to address 2 is attempted on cycle err_at (if in range).
  task automatic sweep32(input int err_at);
    for (int i = 0; i < 32; i++) begin
      bit we;
      logic [4:0] ra;
      we = (i == err_at);
      ra = i[4:0];
      cyc(0, 0, we, 5'd2, 8'h77, ra, 1, 8'h00, 0, 8'h00, 0, (i < 31), we);
    end
  endtask

  // Monitor: compare DUT outputs #1 after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("step %0d: q1=%02h/%0b q0=%02h/%0b busy=%0b/%0b err=%0b/%0b",
                 e.id, q1, qv1, q0, qv0, busy1, busy0, err1, err0);
        chk("busy_byp", e.id, {7'd0, busy1}, {7'd0, e.busy});
        chk("busy_old", e.id, {7'd0, busy0}, {7'd0, e.busy});
        chk("wr_err_byp", e.id, {7'd0, err1}, {7'd0, e.err});
        chk("wr_err_old", e.id, {7'd0, err0}, {7'd0, e.err});
        if (e.cq) begin
          chk("q_byp", e.id, q1, e.q1);
          chk("q_valid_byp", e.id, {7'd0, qv1}, {7'd0, e.v1});
          chk("q_old", e.id, q0, e.q0);
          chk("q_valid_old", e.id, {7'd0, qv0}, {7'd0, e.v0});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    logic [7:0] wv;
    logic [4:0] a;
    reset = 1'b1; clear = 1'b0; data = '0; wraddress = '0; wren = 1'b0; rdaddress = '0;

    // Reset for 3 cycles, then the full sweep with a dropped write at cycle 10.
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    sweep32(10);
    // Every entry reads INIT_VAL, not written.
    for (int i = 0; i < 32; i++) begin
      a = i[4:0];
      cyc(0, 0, 0, 0, 0, a, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    end

    // Load 0x11..0x44 into addresses 0..3 while reading address 31.
    for (int i = 0; i < 4; i++) begin
      a = i[4:0];
      wv = 8'(17 * (i + 1));
      cyc(0, 0, 1, a, wv, 5'd31, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    end
    // Read back 0..4.
    for (int i = 0; i < 5; i++) begin
      a = i[4:0];
      wv = (i < 4) ? 8'(17 * (i + 1)) : 8'h00;
      cyc(0, 0, 0, 0, 0, a, 1, wv, (i < 4), wv, (i < 4), 0, 0);
    end

    // Same-address read-during-write at address 5.
    cyc(0, 0, 1, 5'd5, 8'h5A, 5'd5, 1, 8'h5A, 1, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 5'd5, 1, 8'h5A, 1, 8'h5A, 1, 0, 0);

    // clear together with a write: write dropped, sweep restarts.
    cyc(0, 1, 1, 5'd6, 8'h66, 5'd31, 1, 8'h00, 0, 8'h00, 0, 1, 1);
    sweep32(10);
    for (int i = 0; i < 8; i++) begin
      a = i[4:0];
      cyc(0, 0, 0, 0, 0, a, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    end

    // Mid-sweep clear at sweep cycle 20.
    cyc(0, 0, 1, 5'd9, 8'h99, 5'd31, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 5'd9, 1, 8'h99, 1, 8'h99, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 5'd31, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    for (int i = 1; i < 20; i++) begin
      a = i[4:0];
      cyc(0, 0, 0, 0, 0, a, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    end
    cyc(0, 1, 0, 0, 0, 5'd0, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    sweep32(-1);
    cyc(0, 0, 0, 0, 0, 5'd9, 1, 8'h00, 0, 8'h00, 0, 0, 0);

    // Mid-sweep reset; a write during reset must not raise wr_err.
    cyc(0, 0, 1, 5'd9, 8'h99, 5'd31, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 5'd31, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    for (int i = 1; i < 11; i++) begin
      a = i[4:0];
      cyc(0, 0, 0, 0, 0, a, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    end
    cyc(1, 0, 1, 5'd3, 8'hEE, 5'd9, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 5'd9, 1, 8'h00, 0, 8'h00, 0, 1, 0);
    sweep32(-1);
    cyc(0, 0, 0, 0, 0, 5'd9, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 5'd3, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 5'd0, 1, 8'h00, 0, 8'h00, 0, 0, 0);

    // Drain the scoreboard.
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cail_param_store.md
# cail_param_store

Parametrised successor to the 32×8 calibration-parameter RAM. It provides a simple-dual-port store (one write port, one read port) with configurable width and depth, and a self-clearing initialisation sweep after reset or on request. It also tracks per-entry written flags and offers optional read-during-write bypass. It sits between the calibration loader (writer) and the datapath correction logic (reader), so consumers can tell whether a coefficient has actually been loaded.

## Interface
Parameters:
- DATA_W, default 8: word width.
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
- INIT_VAL, default 0: value written to every entry during a sweep.
- BYPASS, default 1: 1 means same-address read-during-write returns new data; 0 returns old data.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle request to re-run the init sweep.
- data  in  DATA_W  write data.
- wraddress  in  ADDR_W  write address.
- wren  in  1  write enable.
- rdaddress  in  ADDR_W  read address, sampled every cycle.
- q  out  DATA_W  read data.
- q_valid  out  1  the entry read into q has been written since the last sweep.
- busy  out  1  init sweep in progress.
- wr_err  out  1  one-cycle pulse: a write was dropped because busy was high.

## Operation
- FSM states are INIT and IDLE.
- While reset is high: state = INIT, sweep pointer = 0, written vector = 0, q = 0, q_valid = 0, wr_err = 0, busy = 1.
- INIT state:
  - Each cycle writes INIT_VAL to mem[ptr], then increments ptr.
  - When ptr = DEPTH-1 has been written, the next state is IDLE.
  - The sweep takes exactly DEPTH cycles.
- IDLE state:
  - wren=1 writes data to mem[wraddress] and sets written[wraddress].
  - clear=1 moves to INIT with ptr = 0 and clears the written vector in the same edge.
  - If clear and wren are high in the same cycle, clear wins: the write is dropped and wr_err pulses.
- In INIT, user writes are ignored and wr_err=1 on the following cycle for each one.
- clear during INIT restarts the sweep at ptr = 0.
- Reads:
  - Reads proceed in all states.
  - In INIT, q = INIT_VAL and q_valid = 0.
- Read-during-write, same address, in IDLE:
  - BYPASS=1: q = data and q_valid = 1.
  - BYPASS=0: q = old contents and q_valid = the old flag.
- Addresses wrap naturally at DEPTH (no out-of-range case exists).
- The memory array itself is not reset; it is only initialised by the sweep.

## Timing
- Read latency is 1 cycle: rdaddress sampled at edge N gives q/q_valid valid after edge N, stable until edge N+1.
- Write latency is 1 cycle: a write at edge N is readable by a read sampled at edge N+1; at edge N itself the BYPASS rule applies.
- busy:
  - Rises on the first edge with reset or clear high.
  - After the reset edge where reset drops, busy stays high for DEPTH edges and falls on the DEPTH-th edge.
- wr_err is registered: high for exactly 1 cycle after each dropped write.
- Back-to-back writes at full rate are supported; there is no handshake beyond busy.

## Structure
- Package cail_param_pkg holds:
  - the state encoding (ST_IDLE, ST_INIT);
  - default DATA_W/ADDR_W/INIT_VAL constants.
- Sub-module cail_param_ram: an inferable simple-dual-port RAM, registered read, parameters DATA_W/ADDR_W, no reset. The top module muxes its write port between the sweep and the user.
- The written vector (DEPTH flops), bypass compare, FSM and wr_err live in the top module.

## Test plan
- Reset sweep: hold reset 3 cycles, release → busy high for exactly 32 cycles. Every read during and after the sweep returns 0x00 with q_valid=0.
- Write/readback: after busy falls, write 0x11, 0x22, 0x33, 0x44 to addresses 0–3. Read addresses 0–3 → q = 0x11..0x44 one cycle after each address, q_valid=1. Address 4 reads 0x00 with q_valid=0.
- Bypass: same-cycle wren with wraddress=rdaddress=5, data=0x5A:
  - BYPASS=1 → q=0x5A, q_valid=1;
  - BYPASS=0 → q=0x00, q_valid=0; the next read of address 5 gives 0x5A.
- Write during busy: wren=1 to address 2 with 0x77 at sweep cycle 10 → wr_err pulses 1 cycle. After the sweep, address 2 reads 0x00 with q_valid=0.
- Clear: load addresses 0–3, pulse clear → busy high 32 cycles; all entries read INIT_VAL with q_valid=0. clear+wren in the same cycle → wr_err pulses and the write is dropped.
- Mid-sweep clear and reset: pulse clear at sweep cycle 20 → busy lasts 32 more cycles. Assert reset mid-sweep → same restart behaviour.
